// File: rtl/fetch_seq.sv
// fetch_seq: multicycle instruction-fetch sequencer that owns the program counter.
// Issues a handshaked imem fetch with a wait timeout, then resolves branch/jump/halt on ex_done.
module fetch_seq #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        ex_done,
  input  logic [2:0]  npc_sel,
  input  logic        zero,
  input  logic [15:0] imm,
  input  logic [25:0] jump_addr,
  input  logic [31:0] bus_a,
  output logic [31:0] pc,
  output logic        halted,
  output logic        fetch_err,
  output logic [31:0] retired
);
  // state | meaning
  // FETCH | idle; issues a request when not stalled
  // WAIT  | request outstanding; counting toward timeout
  // EXEC  | instruction held for the datapath until ex_done
  // HALT  | stopped by a halt select; terminal until reset
  // ERR   | fetch timed out; terminal until reset
  typedef enum logic [2:0] {S_FETCH, S_WAIT, S_EXEC, S_HALT, S_ERR} state_t;

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  state_t        state_q;
  logic [31:0]   pc_q, inst_q, retired_q;
  logic [TW-1:0] timer_q;
  logic          req_q, iv_q, halt_q, err_q;
  logic [31:0]   npc_d, seq_pc, br_pc;

  assign seq_pc = pc_q + 32'd1;
  assign br_pc  = seq_pc + {{16{imm[15]}}, imm};

  always_comb begin
    npc_d = seq_pc;
    case (npc_sel)
      3'b001:         if (zero)  npc_d = br_pc;
      3'b010:         if (!zero) npc_d = br_pc;
      3'b011, 3'b100: npc_d = {6'b0, jump_addr};
      3'b101:         npc_d = bus_a;
      3'b110:         npc_d = pc_q;
      default:        npc_d = seq_pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      inst_q    <= '0;
      retired_q <= '0;
      timer_q   <= '0;
      req_q     <= 1'b0;
      iv_q      <= 1'b0;
      halt_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (!stall) begin
            state_q <= S_WAIT;
            req_q   <= 1'b1;
            timer_q <= '0;
          end
        end
        S_WAIT: begin
          // an ack arriving on the last allowed cycle still counts
          if (imem_ack) begin
            inst_q  <= imem_rdata;
            req_q   <= 1'b0;
            iv_q    <= 1'b1;
            state_q <= S_EXEC;
          end else if (timer_q == TLAST) begin
            req_q   <= 1'b0;
            err_q   <= 1'b1;
            state_q <= S_ERR;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        S_EXEC: begin
          if (ex_done) begin
            pc_q      <= npc_d;
            iv_q      <= 1'b0;
            retired_q <= retired_q + 32'd1;
            if (npc_sel == 3'b110) begin
              halt_q  <= 1'b1;
              state_q <= S_HALT;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign imem_req   = req_q;
  assign imem_addr  = pc_q;
  assign inst       = inst_q;
  assign inst_valid = iv_q;
  assign pc         = pc_q;
  assign halted     = halt_q;
  assign fetch_err  = err_q;
  assign retired    = retired_q;
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: transaction-level reference model of fetch_seq; outputs compared every negedge.
module tb_fetch_seq;
  localparam int          TO  = 15;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic        clk = 1'b0, rst_n = 1'b1, stall = 1'b1, imem_ack = 1'b0, ex_done = 1'b0, zero = 1'b0;
  logic [31:0] imem_rdata = '0, bus_a = '0;
  logic [2:0]  npc_sel = '0;
  logic [15:0] imm = '0;
  logic [25:0] jump_addr = '0;
  logic        imem_req, inst_valid, halted, fetch_err;
  logic [31:0] imem_addr, inst, pc, retired;

  int n_chk = 0, n_err = 0, cycles = 0;
  logic [31:0] e_pc, e_inst, e_ret;
  logic        e_req, e_iv, e_halt, e_err;

  fetch_seq #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
    .ex_done(ex_done), .npc_sel(npc_sel), .zero(zero), .imm(imm), .jump_addr(jump_addr),
    .bus_a(bus_a), .pc(pc), .halted(halted), .fetch_err(fetch_err), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // per-cycle comparison against the model
  always @(negedge clk) begin
    chk("imem_req",   32'(imem_req),   32'(e_req));
    chk("imem_addr",  imem_addr,       e_pc);
    chk("pc",         pc,              e_pc);
    chk("inst",       inst,            e_inst);
    chk("inst_valid", 32'(inst_valid), 32'(e_iv));
    chk("halted",     32'(halted),     32'(e_halt));
    chk("fetch_err",  32'(fetch_err),  32'(e_err));
    chk("retired",    retired,         e_ret);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1);
  end

  function automatic logic [31:0] next_pc(logic [31:0] p, logic [2:0] s, logic z,
                                          logic [15:0] im, logic [25:0] ja, logic [31:0] ba);
    logic [31:0] off;
    off = 32'($signed(im));
    if ((s == 3'd1 && z) || (s == 3'd2 && !z)) return p + 32'd1 + off;
    if (s == 3'd3 || s == 3'd4) return 32'(ja);
    if (s == 3'd5) return ba;
    if (s == 3'd6) return p;
    return p + 32'd1;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
    cycles++;
  endtask

  task automatic rand_inputs();
    stall      = 1'($urandom);
    imem_ack   = 1'($urandom);
    imem_rdata = $urandom;
    ex_done    = 1'($urandom);
    npc_sel    = 3'($urandom);
    zero       = 1'($urandom);
    imm        = 16'($urandom);
    jump_addr  = 26'($urandom);
    bus_a      = $urandom;
  endtask

  task automatic reset_exp();
    e_pc = RPC; e_inst = '0; e_ret = '0;
    e_req = 1'b0; e_iv = 1'b0; e_halt = 1'b0; e_err = 1'b0;
  endtask

  task automatic do_reset();
    stall = 1'b1; imem_ack = 1'b0; ex_done = 1'b0;
    rst_n = 1'b0;
    reset_exp();
    cyc(); cyc();
    rst_n = 1'b1;
  endtask

  // One instruction: ns stall cycles, ack on WAIT cycle k (0 = never), nd EXEC idle cycles.
  task automatic instr(int ns, int k, int nd, logic [2:0] sel, logic z,
                       logic [15:0] im, logic [25:0] ja, logic [31:0] ba);
    bit timed_out = 1'b0;
    for (int i = 0; i < ns; i++) begin
      rand_inputs(); stall = 1'b1; cyc();
    end
    rand_inputs(); stall = 1'b0; cyc();
    e_req = 1'b1;
    for (int i = 1; i <= TO; i++) begin
      rand_inputs();
      if (i == k) begin
        imem_ack = 1'b1; cyc();
        e_req = 1'b0; e_inst = imem_rdata; e_iv = 1'b1;
        break;
      end
      imem_ack = 1'b0; cyc();
      if (i == TO) begin
        e_req = 1'b0; e_err = 1'b1; timed_out = 1'b1;
      end
    end
    if (!timed_out) begin
      for (int i = 0; i < nd; i++) begin
        rand_inputs(); ex_done = 1'b0; cyc();
      end
      rand_inputs();
      ex_done = 1'b1; npc_sel = sel; zero = z; imm = im; jump_addr = ja; bus_a = ba;
      cyc();
      e_pc = next_pc(e_pc, sel, z, im, ja, ba);
      e_iv = 1'b0;
      e_ret = e_ret + 32'd1;
      if (sel == 3'b110) e_halt = 1'b1;
    end
    ex_done = 1'b0; imem_ack = 1'b0; stall = 1'b1;
  endtask

  task automatic noise(int n);
    for (int i = 0; i < n; i++) begin
      rand_inputs(); cyc();
    end
  endtask

  initial begin
    logic [31:0] p0, r0;
    reset_exp();
    #1;
    do_reset();
    chk("rst_pc", pc, 32'h0);
    chk("rst_retired", retired, 32'h0);

    // sequential run, 3 cycles per instruction
    cycles = 0;
    for (int i = 0; i < 4; i++) begin
      chk("seq_addr", imem_addr, 32'(i));
      instr(0, 1, 0, 3'b000, 1'b0, 16'h0, 26'h0, 32'h0);
    end
    chk("seq_retired", retired, 32'd4);
    chk("seq_cycles", 32'(cycles), 32'd12);

    // branches
    instr(0, 1, 0, 3'b101, 1'b0, 16'h0, 26'h0, 32'd10);
    chk("jr_10", pc, 32'd10);
    instr(0, 1, 0, 3'b001, 1'b1, 16'hFFFC, 26'h0, 32'h0);
    chk("beq_taken", pc, 32'd7);
    instr(0, 1, 0, 3'b101, 1'b0, 16'h0, 26'h0, 32'd10);
    instr(0, 1, 0, 3'b010, 1'b1, 16'hFFFC, 26'h0, 32'h0);
    chk("bne_not_taken", pc, 32'd11);
    instr(0, 1, 0, 3'b101, 1'b0, 16'h0, 26'h0, 32'd10);
    instr(0, 1, 0, 3'b001, 1'b0, 16'hFFFC, 26'h0, 32'h0);
    chk("beq_not_taken", pc, 32'd11);

    // jumps and wrap
    instr(0, 1, 0, 3'b011, 1'b0, 16'h0, 26'h3FF_FFFF, 32'h0);
    chk("j_max", pc, 32'h03FF_FFFF);
    instr(0, 1, 0, 3'b101, 1'b0, 16'h0, 26'h0, 32'h1234);
    chk("jr_1234", pc, 32'h1234);
    instr(0, 1, 0, 3'b101, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFF);
    instr(0, 1, 0, 3'b111, 1'b0, 16'h0, 26'h0, 32'h0);
    chk("wrap", pc, 32'h0);

    // stall for 5 cycles, then ack delayed 3 cycles, then ack on the final timeout cycle
    instr(5, 4, 2, 3'b000, 1'b0, 16'h0, 26'h0, 32'h0);
    chk("stall_delay_pc", pc, 32'h1);
    instr(0, TO, 0, 3'b000, 1'b0, 16'h0, 26'h0, 32'h0);
    chk("late_ack_no_err", 32'(fetch_err), 32'd0);
    chk("late_ack_pc", pc, 32'h2);

    // randomized traffic, non-terminal selects only
    for (int n = 0; n < 150; n++) begin
      logic [2:0] s;
      int k;
      s = 3'($urandom);
      if (s == 3'b110) s = 3'b000;
      k = ($urandom_range(0, 3) == 0) ? $urandom_range(1, TO) : $urandom_range(1, 3);
      instr($urandom_range(0, 3), k, $urandom_range(0, 3), s, 1'($urandom),
            16'($urandom), 26'($urandom), $urandom);
    end

    // halt is terminal
    p0 = e_pc; r0 = e_ret;
    instr(1, 2, 1, 3'b110, 1'b0, 16'h0, 26'h0, 32'h0);
    chk("halted", 32'(halted), 32'd1);
    chk("halt_pc", pc, p0);
    chk("halt_retired", retired, r0 + 32'd1);
    noise(12);

    // reset asserted mid-WAIT
    do_reset();
    stall = 1'b0; cyc(); e_req = 1'b1;
    stall = 1'b1; imem_ack = 1'b0; cyc(); cyc();
    #2 rst_n = 1'b0;
    reset_exp();
    #1;
    chk("rst_req_drop", 32'(imem_req), 32'd0);
    chk("rst_pc_wait", pc, RPC);
    do_reset();

    // timeout is terminal
    instr(0, 0, 0, 3'b000, 1'b0, 16'h0, 26'h0, 32'h0);
    chk("timeout_err", 32'(fetch_err), 32'd1);
    chk("timeout_req", 32'(imem_req), 32'd0);
    noise(12);

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction-fetch sequencer that owns the program counter and drives the next-PC computation for the simple CPU. Runs a multicycle fetch/execute loop: issues a word-addressed request to instruction memory, holds the returned instruction for the datapath, then, on the datapath's completion strobe, resolves branch, jump and halt selects into the next PC. Sits between the instruction memory port and the decode/execute datapath. Replaces free-running PC+1 stepping with a handshaked, stall-aware, timeout-protected sequence.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset (word address)
- TIMEOUT, 15, max WAIT cycles without imem_ack before fetch error (≥1)

- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- stall  in  1  hold in FETCH (no new request issued)
- imem_req  out  1  fetch request, level, held until ack
- imem_addr  out  32  word address of fetch (= pc)
- imem_ack  in  1  instruction data valid this cycle
- imem_rdata  in  32  instruction word
- inst  out  32  latched instruction
- inst_valid  out  1  high throughout EXEC
- ex_done  in  1  datapath finished current instruction; select fields below valid this cycle
- npc_sel  in  3  001 beq, 010 bne, 011 j, 100 jal, 101 jr, 110 halt, others sequential
- zero  in  1  ALU equality flag
- imm  in  16  branch offset, words
- jump_addr  in  26  jump target, words
- bus_a  in  32  register value for jr
- pc  out  32  current PC
- halted  out  1  high in HALT
- fetch_err  out  1  high in ERR
- retired  out  32  instructions completed

## Operation
- States: FETCH, WAIT, EXEC, HALT, ERR. All outputs registered.
- Reset (async, rst_n=0): state FETCH, pc=RESET_PC, imem_req=0, inst=0, inst_valid=0, halted=0, fetch_err=0, retired=0, wait timer=0. imem_req drops immediately on reset assertion, including mid-WAIT.
- FETCH: stall=1 → stay. stall=0 → WAIT, imem_req←1, timer←0.
- WAIT: imem_addr=pc. imem_ack=1 → inst←imem_rdata, imem_req←0, inst_valid←1, EXEC. Otherwise timer+1. If timer==TIMEOUT-1 and no ack → imem_req←0, fetch_err←1, ERR. Ack on the timeout cycle wins.
- EXEC: ex_done=0 → hold. ex_done=1 → pc←next_pc, inst_valid←0, retired+1 (wraps mod 2^32). Then HALT if npc_sel==110, otherwise FETCH.
- next_pc (mod 2^32, word units, sext = sign-extend imm to 32 bits):
  - 001 with zero=1, or 010 with zero=0: pc+1+sext(imm)
  - 011, 100: {6'b0, jump_addr}
  - 101: bus_a
  - 110: pc (unchanged)
  - all else, including branch-not-taken: pc+1
- HALT and ERR are terminal until reset. In both, all inputs are ignored.
- Inputs are ignored outside their state: imem_ack outside WAIT, ex_done outside EXEC, stall outside FETCH.
- stall does not cancel an outstanding request.

## Timing
- imem_req rises on the edge leaving FETCH. It falls on the edge after the ack is sampled.
- Minimum of 3 cycles per instruction: FETCH, WAIT with ack, EXEC with ex_done.
- inst and inst_valid are valid from the edge after the ack until the edge after ex_done.
- pc and retired update on the same edge that leaves EXEC. imem_addr for the next fetch reflects the new pc.
- fetch_err asserts on the edge after TIMEOUT consecutive WAIT cycles without ack.

## Test plan
- Sequential: RESET_PC=0, ack after 1 cycle, ex_done immediately, npc_sel=000 for 4 instructions → fetch addrs 0,1,2,3; retired=4; 3 cycles per instruction.
- Branches: pc=10, beq imm=16'hFFFC zero=1 → pc=7. bne zero=1 → pc=11. beq zero=0 → pc=11.
- Jumps: j jump_addr=26'h3FF_FFFF → pc=32'h03FF_FFFF. jr bus_a=32'h1234 → pc=32'h1234. Wrap case: pc=32'hFFFF_FFFF sequential → pc=0.
- Handshake and stall: stall=1 for 5 cycles → imem_req stays 0. Ack delayed 3 cycles → imem_req held high, imem_addr stable, inst latched on ack.
- Timeout: TIMEOUT=15, no ack → fetch_err=1 after 15 WAIT cycles, imem_req=0. Ack on the 15th cycle → no error, EXEC entered.
- Halt and reset: npc_sel=110 → halted=1, pc unchanged, retired incremented, later ex_done/ack ignored. rst_n pulsed low mid-WAIT → imem_req=0 immediately, pc=RESET_PC, state FETCH.
